// File: rtl/pipe_ctrl.sv
// Hazard and pipeline-control unit for the 5-stage RV64IM core: stall/flush
// generation, MDU occupancy tracking, trap-entry sequencing and stall counting.
module pipe_ctrl #(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 33,
  parameter int CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic             ex_load_i,
  input  logic             ex_wen_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_mdu_start_i,
  input  logic             ex_is_div_i,
  input  logic             ex_redirect_i,
  input  logic             mem_exception_i,
  output logic             stall_if_id_o,
  output logic             flush_if_id_o,
  output logic             stall_id_ex_o,
  output logic             flush_id_ex_o,
  output logic             flush_ex_mem_o,
  output logic             pc_stall_o,
  output logic             trap_redirect_o,
  output logic             mdu_busy_o,
  output logic             mdu_done_o,
  output logic [CNT_W-1:0] stall_cycles_o
);

  typedef enum logic {IDLE = 1'b0, TRAP = 1'b1} state_e;

  localparam logic [5:0] MUL_LOAD  = 6'(MUL_LAT - 1);
  localparam logic [5:0] DIV_LOAD  = 6'(DIV_LAT - 1);
  localparam logic       MUL_MULTI = (MUL_LAT > 1);
  localparam logic       DIV_MULTI = (DIV_LAT > 1);

  state_e           state_q, state_d;
  logic [5:0]       mdu_cnt_q, mdu_cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic exc_take, in_trap, start_multi, start_single;
  logic mdu_busy, mdu_done, hazard;
  logic stall_if_id, flush_if_id, stall_id_ex, flush_id_ex;
  logic flush_ex_mem, pc_stall, trap_redirect;

  // A new exception is only taken from IDLE; TRAP already holds the pipeline flushed.
  assign exc_take = (state_q == IDLE) & mem_exception_i;
  assign in_trap  = (state_q == TRAP);

  assign start_multi  = ex_mdu_start_i & (ex_is_div_i ? DIV_MULTI : MUL_MULTI);
  assign start_single = ex_mdu_start_i & (mdu_cnt_q == 6'd0) & ~start_multi;

  assign mdu_busy = ~exc_take & ~in_trap & ((mdu_cnt_q != 6'd0) | start_multi);
  assign mdu_done = ~exc_take & ~in_trap & ((mdu_cnt_q == 6'd1) | start_single);

  assign hazard = ex_load_i & ex_wen_i & (ex_rd_i != 5'd0) &
                  ((id_use_rs1_i & (id_rs1_i == ex_rd_i)) |
                   (id_use_rs2_i & (id_rs2_i == ex_rd_i)));

  always_comb begin
    stall_if_id   = 1'b0;
    flush_if_id   = 1'b0;
    stall_id_ex   = 1'b0;
    flush_id_ex   = 1'b0;
    flush_ex_mem  = 1'b0;
    pc_stall      = 1'b0;
    trap_redirect = 1'b0;
    if (exc_take | in_trap) begin
      flush_if_id   = 1'b1;
      flush_id_ex   = 1'b1;
      flush_ex_mem  = 1'b1;
      trap_redirect = exc_take;
    end else if (mdu_busy & ~mdu_done) begin
      // ex_mem cannot hold, so it takes a bubble while EX is occupied.
      stall_if_id  = 1'b1;
      stall_id_ex  = 1'b1;
      pc_stall     = 1'b1;
      flush_ex_mem = 1'b1;
    end else if (ex_redirect_i) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (hazard) begin
      stall_if_id = 1'b1;
      pc_stall    = 1'b1;
      flush_id_ex = 1'b1;
    end
  end

  always_comb begin
    state_d        = state_q;
    mdu_cnt_d      = mdu_cnt_q;
    stall_cycles_d = stall_cycles_q;
    case (state_q)
      IDLE:    if (mem_exception_i) state_d = TRAP;
      TRAP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (exc_take | in_trap) begin
      mdu_cnt_d = 6'd0;
    end else if (mdu_cnt_q != 6'd0) begin
      mdu_cnt_d = mdu_cnt_q - 6'd1;
    end else if (ex_mdu_start_i) begin
      mdu_cnt_d = ex_is_div_i ? DIV_LOAD : MUL_LOAD;
    end
    if (pc_stall && !(&stall_cycles_q)) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      mdu_cnt_q      <= 6'd0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      mdu_cnt_q      <= mdu_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // Combinational outputs are forced low for as long as reset is held.
  assign stall_if_id_o   = rst_ni & stall_if_id;
  assign flush_if_id_o   = rst_ni & flush_if_id;
  assign stall_id_ex_o   = rst_ni & stall_id_ex;
  assign flush_id_ex_o   = rst_ni & flush_id_ex;
  assign flush_ex_mem_o  = rst_ni & flush_ex_mem;
  assign pc_stall_o      = rst_ni & pc_stall;
  assign trap_redirect_o = rst_ni & trap_redirect;
  assign mdu_busy_o      = rst_ni & mdu_busy;
  assign mdu_done_o      = rst_ni & mdu_done;
  assign stall_cycles_o  = stall_cycles_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: expected control vectors are queued as each
// step is driven and compared once the outputs have settled.
module tb_pipe_ctrl;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic id_use_rs1 = 0, id_use_rs2 = 0, ex_load = 0, ex_wen = 0;
  logic ex_mdu_start = 0, ex_is_div = 0, ex_redirect = 0, mem_exception = 0;
  logic stall_if_id, flush_if_id, stall_id_ex, flush_id_ex, flush_ex_mem;
  logic pc_stall, trap_redirect, mdu_busy, mdu_done;
  logic [CW-1:0] stall_cycles;

  always #5 clk = ~clk;

  pipe_ctrl #(.MUL_LAT(3), .DIV_LAT(33), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2),
    .ex_load_i(ex_load), .ex_wen_i(ex_wen), .ex_rd_i(ex_rd),
    .ex_mdu_start_i(ex_mdu_start), .ex_is_div_i(ex_is_div),
    .ex_redirect_i(ex_redirect), .mem_exception_i(mem_exception),
    .stall_if_id_o(stall_if_id), .flush_if_id_o(flush_if_id),
    .stall_id_ex_o(stall_id_ex), .flush_id_ex_o(flush_id_ex),
    .flush_ex_mem_o(flush_ex_mem), .pc_stall_o(pc_stall),
    .trap_redirect_o(trap_redirect), .mdu_busy_o(mdu_busy),
    .mdu_done_o(mdu_done), .stall_cycles_o(stall_cycles)
  );

  // {stall_if_id, flush_if_id, stall_id_ex, flush_id_ex, flush_ex_mem,
  //  pc_stall, trap_redirect, mdu_busy, mdu_done}
  localparam logic [8:0] NONE  = 9'b0_0_0_0_0_0_0_0_0;
  localparam logic [8:0] LU    = 9'b1_0_0_1_0_1_0_0_0;
  localparam logic [8:0] MSTL  = 9'b1_0_1_0_1_1_0_1_0;
  localparam logic [8:0] MDONE = 9'b0_0_0_0_0_0_0_1_1;
  localparam logic [8:0] EXC   = 9'b0_1_0_1_1_0_1_0_0;
  localparam logic [8:0] TRAPV = 9'b0_1_0_1_1_0_0_0_0;
  localparam logic [8:0] REDIR = 9'b0_1_0_1_0_0_0_0_0;

  typedef struct {
    string      tag;
    logic [8:0] ctl;
    logic [CW-1:0] sc;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  logic [CW-1:0] exp_sc = '0;

  function automatic logic [8:0] obs_vec();
    return {stall_if_id, flush_if_id, stall_id_ex, flush_id_ex, flush_ex_mem,
            pc_stall, trap_redirect, mdu_busy, mdu_done};
  endfunction

  // Queue the expectation for the step just driven, let it settle, then compare.
  task automatic check(input string tag, input logic [8:0] ctl);
    exp_t e;
    exp_q.push_back('{tag: tag, ctl: ctl, sc: exp_sc});
    #2;
    e = exp_q.pop_front();
    n_cmp++;
    assert (obs_vec() === e.ctl)
    else begin
      n_bad++;
      $error("FAIL %s ctl: observed %b expected %b", e.tag, obs_vec(), e.ctl);
    end
    n_cmp++;
    assert (stall_cycles === e.sc)
    else begin
      n_bad++;
      $error("FAIL %s stall_cycles: observed %0d expected %0d", e.tag, stall_cycles, e.sc);
    end
    $display("step %-12s ctl=%b sc=%0d", e.tag, obs_vec(), stall_cycles);
    if (ctl[3] && exp_sc != {CW{1'b1}}) exp_sc = exp_sc + 1'b1;
  endtask

  task automatic idle_inputs();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_use_rs1 = 0; id_use_rs2 = 0; ex_load = 0; ex_wen = 0;
    ex_mdu_start = 0; ex_is_div = 0; ex_redirect = 0; mem_exception = 0;
  endtask

  task automatic set_lu(input logic [4:0] rd);
    ex_load = 1; ex_wen = 1; ex_rd = rd; id_rs2 = 5'd5; id_use_rs2 = 1;
  endtask

  task automatic check_cnt0(input string tag);
    n_cmp++;
    assert (dut.mdu_cnt_q === 6'd0)
    else begin
      n_bad++;
      $error("FAIL %s mdu_cnt: observed %0d expected 0", tag, dut.mdu_cnt_q);
    end
  endtask

  // Starting a new MDU op while one is in flight must never happen.
  always @(posedge clk) begin
    if (rst_n && ex_mdu_start) begin
      n_cmp++;
      assert (dut.mdu_cnt_q == 6'd0)
      else begin
        n_bad++;
        $error("FAIL illegal_start mdu_cnt: observed %0d expected 0", dut.mdu_cnt_q);
      end
    end
  end

  initial begin
    @(negedge clk); check("reset", NONE);
    @(negedge clk); rst_n = 1; check("idle", NONE);

    @(negedge clk); set_lu(5'd5); check("lu_rs2", LU);
    @(negedge clk); set_lu(5'd0); id_rs2 = 5'd0; check("lu_x0", NONE);
    @(negedge clk); idle_inputs(); ex_load = 1; ex_wen = 1; ex_rd = 5'd7;
    id_rs1 = 5'd7; id_use_rs1 = 1; check("lu_rs1", LU);
    @(negedge clk); id_use_rs1 = 0; check("lu_nouse", NONE);
    @(negedge clk); ex_wen = 0; id_use_rs1 = 1; check("lu_nowen", NONE);

    @(negedge clk); idle_inputs(); ex_mdu_start = 1; check("mul_c1", MSTL);
    @(negedge clk); ex_mdu_start = 0; check("mul_c2", MSTL);
    @(negedge clk); check("mul_c3", MDONE);
    @(negedge clk); check("mul_after", NONE);

    @(negedge clk); set_lu(5'd5); ex_redirect = 1; check("redir_lu", REDIR);

    @(negedge clk); idle_inputs(); ex_mdu_start = 1; ex_is_div = 1; check("div_c1", MSTL);
    @(negedge clk); ex_mdu_start = 0; ex_is_div = 0;
    for (int i = 2; i <= 9; i++) begin
      check($sformatf("div_c%0d", i), MSTL);
      @(negedge clk);
    end
    mem_exception = 1; check("div_exc", EXC);
    @(negedge clk); check("trap", TRAPV);
    check_cnt0("trap");
    @(negedge clk); mem_exception = 0; check("post_trap", NONE);
    check_cnt0("post_trap");

    for (int i = 0; i < 20; i++) begin
      @(negedge clk); set_lu(5'd5); check($sformatf("sat_%0d", i), LU);
    end
    @(negedge clk); idle_inputs(); check("sat_end", NONE);

    @(negedge clk); ex_mdu_start = 1; ex_is_div = 1; check("rdiv_c1", MSTL);
    @(negedge clk); ex_mdu_start = 0; ex_is_div = 0;
    for (int i = 0; i < 12; i++) begin
      check($sformatf("rdiv_%0d", i), MSTL);
      @(negedge clk);
    end
    set_lu(5'd5); rst_n = 0; exp_sc = '0; check("rst_mid", NONE);
    check_cnt0("rst_mid");
    @(negedge clk); idle_inputs(); rst_n = 1; check("rel_0", NONE);
    @(negedge clk); check("rel_1", NONE);
    @(negedge clk); check("rel_2", NONE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
